// File: rtl/control_sequencer_pkg.sv
// ctrl_seq_pkg: shared state/trap-cause encodings for the control sequencer.
package ctrl_seq_pkg;
  localparam int STATE_W = 3;
  localparam int CAUSE_W = 3;
  typedef enum logic [STATE_W-1:0] {
    S_HALT       = 3'd0,
    S_FETCH      = 3'd1,
    S_EXEC       = 3'd2,
    S_WAIT_LOAD  = 3'd3,
    S_WAIT_STORE = 3'd4,
    S_TRAP       = 3'd5
  } state_t;
  typedef enum logic [CAUSE_W-1:0] {
    C_NONE       = 3'd0,
    C_INSTR_SEGV = 3'd1,
    C_ILLEGAL    = 3'd2,
    C_DATA_SEGV  = 3'd3,
    C_TIMEOUT    = 3'd4
  } cause_t;
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: memory/decoder inputs and datapath strobes of the control sequencer.
interface control_sequencer_if #(
  parameter int INSTR_W  = 32,
  parameter int RW_W     = 2,
  parameter int RETIRE_W = 32
);
  logic                              go;
  logic                              halt;
  logic [INSTR_W-1:0]                instruction;
  logic                              instr_segv;
  logic                              wait_instr;
  logic                              data_segv;
  logic                              wait_data;
  logic                              dec_invalid;
  logic                              dec_ld;
  logic                              dec_st;
  logic [RW_W-1:0]                   dec_reg_write;
  logic                              dec_pc_inc;
  logic [ctrl_seq_pkg::STATE_W-1:0]  state;
  logic                              pc_inc;
  logic [RW_W-1:0]                   reg_write;
  logic                              ld;
  logic                              st;
  logic [INSTR_W-1:0]                instr_hold;
  logic [ctrl_seq_pkg::CAUSE_W-1:0]  trap_cause;
  logic [RETIRE_W-1:0]               retired;
  modport master (
    input  go, halt, instruction, instr_segv, wait_instr, data_segv, wait_data,
           dec_invalid, dec_ld, dec_st, dec_reg_write, dec_pc_inc,
    output state, pc_inc, reg_write, ld, st, instr_hold, trap_cause, retired
  );
  modport slave (
    output go, halt, instruction, instr_segv, wait_instr, data_segv, wait_data,
           dec_invalid, dec_ld, dec_st, dec_reg_write, dec_pc_inc,
    input  state, pc_inc, reg_write, ld, st, instr_hold, trap_cause, retired
  );
endinterface

// File: rtl/control_sequencer_wait_timer.sv
// wait_timer: counts consecutive wait cycles in a state and flags the last allowed one.
module wait_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  generate
    if (TIMEOUT == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      logic [CW-1:0] r_cnt;
      always_ff @(posedge clk or posedge reset)
        if (reset) r_cnt <= '0;
        else r_cnt <= clear ? '0 : count_en ? r_cnt + CW'(1) : r_cnt;
      assign expired = count_en && (r_cnt == CW'(TIMEOUT - 1));
    end
  endgenerate
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: single-issue fetch/execute/memory-wait sequencer with trap cause,
// wait timeout and retired-instruction counter.
module control_sequencer #(
  parameter int INSTR_W  = 32,
  parameter int RW_W     = 2,
  parameter int TIMEOUT  = 16,
  parameter int RETIRE_W = 32
) (
  input logic clk,
  input logic reset,
  control_sequencer_if.master bus
);
  import ctrl_seq_pkg::*;
  state_t              r_state, w_next;
  cause_t              r_cause, w_cause;
  logic [INSTR_W-1:0]  r_instr_hold;
  logic [RETIRE_W-1:0] r_retired;
  logic                w_commit, w_latch, w_wait, w_expired;
  wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (w_next != r_state),
    .count_en (w_wait),
    .expired  (w_expired)
  );
  always_comb begin
    w_next   = r_state;
    w_cause  = r_cause;
    w_commit = 1'b0;
    w_latch  = 1'b0;
    w_wait   = (r_state == S_FETCH) ? bus.wait_instr :
               (r_state == S_WAIT_LOAD || r_state == S_WAIT_STORE) ? bus.wait_data : 1'b0;
    case (r_state)
      S_HALT:
        if (bus.go && !bus.halt) begin
          w_next  = S_FETCH;
          w_cause = C_NONE;
        end
      S_FETCH:
        if (bus.halt) w_next = S_HALT;
        else if (bus.instr_segv) begin
          w_next  = S_TRAP;
          w_cause = C_INSTR_SEGV;
        end else if (w_expired) begin
          w_next  = S_TRAP;
          w_cause = C_TIMEOUT;
        end else if (!bus.wait_instr) begin
          w_latch = 1'b1;
          w_next  = S_EXEC;
        end
      S_EXEC:
        if (bus.dec_invalid || (bus.dec_ld && bus.dec_st)) begin
          w_next  = S_TRAP;
          w_cause = C_ILLEGAL;
        end else if (bus.dec_ld) w_next = S_WAIT_LOAD;
        else if (bus.dec_st) w_next = S_WAIT_STORE;
        else w_commit = 1'b1;
      S_WAIT_LOAD, S_WAIT_STORE:
        if (bus.data_segv) begin
          w_next  = S_TRAP;
          w_cause = C_DATA_SEGV;
        end else if (w_expired) begin
          w_next  = S_TRAP;
          w_cause = C_TIMEOUT;
        end else if (!bus.wait_data) w_commit = 1'b1;
      S_TRAP:
        if (bus.halt) w_next = S_HALT;
        else if (bus.go) begin
          w_next  = S_FETCH;
          w_cause = C_NONE;
        end
      default: w_next = S_HALT;
    endcase
    // halt is only honoured at the commit boundary once an access is in flight
    if (w_commit) w_next = bus.halt ? S_HALT : S_FETCH;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state      <= S_HALT;
      r_cause      <= C_NONE;
      r_instr_hold <= '0;
      r_retired    <= '0;
    end else begin
      r_state <= w_next;
      r_cause <= w_cause;
      if (w_latch) r_instr_hold <= bus.instruction;
      if (w_commit) r_retired <= r_retired + RETIRE_W'(1);
    end
  assign bus.state      = r_state;
  assign bus.pc_inc     = w_commit && bus.dec_pc_inc;
  assign bus.reg_write  = (w_commit && r_state != S_WAIT_STORE) ? bus.dec_reg_write : '0;
  assign bus.ld         = r_state == S_WAIT_LOAD;
  assign bus.st         = r_state == S_WAIT_STORE;
  assign bus.instr_hold = r_instr_hold;
  assign bus.trap_cause = r_cause;
  assign bus.retired    = r_retired;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed plan scenarios plus random stimulus against a cycle reference model.
module tb_control_sequencer;
  localparam int IW = 32, RW = 2, TO = 4, RTW = 4;
  logic clk = 1'b0;
  logic reset;
  int errs = 0, checks = 0;
  int m_st, m_cause, m_waited, m_ret;
  logic [IW-1:0] m_hold;
  control_sequencer_if #(.INSTR_W(IW), .RW_W(RW), .RETIRE_W(RTW)) bus ();
  control_sequencer #(.INSTR_W(IW), .RW_W(RW), .TIMEOUT(TO), .RETIRE_W(RTW)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    m_st = 0; m_cause = 0; m_waited = 0; m_ret = 0; m_hold = '0;
  endtask
  // Reference: states 0 HALT,1 FETCH,2 EXEC,3 LOAD,4 STORE,5 TRAP; m_waited = wait cycles spent in this state
  task automatic step();
    int nx = m_st, nc = m_cause;
    bit commit = 0, grab = 0, waiting, tout;
    logic [RW-1:0] e_rw;
    waiting = (m_st == 1 && bus.wait_instr) || ((m_st == 3 || m_st == 4) && bus.wait_data);
    tout = waiting && (m_waited + 1 == TO);
    case (m_st)
      0: if (bus.go && !bus.halt) begin nx = 1; nc = 0; end
      1: if (bus.halt) nx = 0;
         else if (bus.instr_segv) begin nx = 5; nc = 1; end
         else if (tout) begin nx = 5; nc = 4; end
         else if (!bus.wait_instr) begin nx = 2; grab = 1; end
      2: if (bus.dec_invalid || (bus.dec_ld && bus.dec_st)) begin nx = 5; nc = 2; end
         else if (bus.dec_ld) nx = 3;
         else if (bus.dec_st) nx = 4;
         else commit = 1;
      3, 4: if (bus.data_segv) begin nx = 5; nc = 3; end
            else if (tout) begin nx = 5; nc = 4; end
            else if (!bus.wait_data) commit = 1;
      default: if (bus.halt) nx = 0; else if (bus.go) begin nx = 1; nc = 0; end
    endcase
    if (commit) nx = bus.halt ? 0 : 1;
    e_rw = (commit && m_st != 4) ? bus.dec_reg_write : '0;
    chk("state", bus.state, m_st);
    chk("pc_inc", bus.pc_inc, commit && bus.dec_pc_inc);
    chk("reg_write", bus.reg_write, e_rw);
    chk("ld", bus.ld, m_st == 3);
    chk("st", bus.st, m_st == 4);
    chk("instr_hold", bus.instr_hold, m_hold);
    chk("trap_cause", bus.trap_cause, m_cause);
    chk("retired", bus.retired, m_ret);
    m_waited = (nx != m_st) ? 0 : m_waited + int'(waiting);
    if (grab) m_hold = bus.instruction;
    if (commit) m_ret = (m_ret + 1) % (1 << RTW);
    m_st = nx;
    m_cause = nc;
  endtask
  task automatic drive(bit g, bit h, logic [IW-1:0] ins, bit is, bit wi, bit ds, bit wd,
                       bit inv, bit l, bit s, logic [RW-1:0] rw, bit pc);
    @(negedge clk);
    bus.go = g; bus.halt = h; bus.instruction = ins; bus.instr_segv = is;
    bus.wait_instr = wi; bus.data_segv = ds; bus.wait_data = wd; bus.dec_invalid = inv;
    bus.dec_ld = l; bus.dec_st = s; bus.dec_reg_write = rw; bus.dec_pc_inc = pc;
    #1 step();
  endtask
  task automatic idle_inputs();
    bus.go = 0; bus.halt = 0; bus.instruction = '0; bus.instr_segv = 0; bus.wait_instr = 0;
    bus.data_segv = 0; bus.wait_data = 0; bus.dec_invalid = 0; bus.dec_ld = 0; bus.dec_st = 0;
    bus.dec_reg_write = '0; bus.dec_pc_inc = 0;
  endtask
  task automatic check_zero(string tag);
    chk({tag, "_state"}, bus.state, 0);
    chk({tag, "_strobes"}, {bus.pc_inc, bus.reg_write, bus.ld, bus.st}, 0);
    chk({tag, "_hold"}, bus.instr_hold, 0);
    chk({tag, "_cause"}, bus.trap_cause, 0);
    chk({tag, "_retired"}, bus.retired, 0);
  endtask
  task automatic mid_reset(string tag);
    @(negedge clk);
    idle_inputs();
    #2 reset = 1'b1;
    #1 check_zero(tag);
    model_reset();
    #1 reset = 1'b0;
  endtask
  task automatic to_exec(logic [IW-1:0] ins);
    drive(1, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    drive(0, 0, ins, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
  endtask
  initial begin
    int r0;
    reset = 1'b0;
    idle_inputs();
    model_reset();
    #1 reset = 1'b1;
    #2 check_zero("reset");
    @(negedge clk);
    #2 reset = 1'b0;
    // plan 1: simple commit
    drive(1, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t1_s0", bus.state, 0);
    drive(0, 0, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t1_s1", bus.state, 1);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1);
    chk("t1_s2", bus.state, 2);
    chk("t1_pc", bus.pc_inc, 1);
    chk("t1_rw", bus.reg_write, 2'b01);
    drive(0, 1, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t1_s3", bus.state, 1);
    chk("t1_ret", bus.retired, 1);
    chk("t1_hold", bus.instr_hold, 32'hDEADBEEF);
    // plan 2: load then store with 3 wait cycles each
    to_exec(32'h1111_0001);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, '0, 0, 0, 0, 1, 0, 1, 0, 2'b11, 1);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 1, 0, 2'b11, 1);
    chk("t2_ld_commit", bus.ld, 1);
    chk("t2_ld_rw", bus.reg_write, 2'b11);
    drive(0, 0, 32'h2222_0002, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 1);
    for (int i = 0; i < 3; i++) drive(0, 0, '0, 0, 0, 0, 1, 0, 0, 1, 2'b11, 1);
    drive(0, 1, '0, 0, 0, 0, 0, 0, 0, 1, 2'b11, 1);
    chk("t2_st_commit", bus.st, 1);
    chk("t2_st_rw", bus.reg_write, 0);
    chk("t2_st_pc", bus.pc_inc, 1);
    // plan 3: fetch timeout
    drive(1, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, '0, 0, 1, 0, 0, 0, 0, 0, 2'b00, 0);
    drive(1, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t3_trap", bus.state, 5);
    chk("t3_cause", bus.trap_cause, 4);
    drive(0, 0, 32'h3333_0003, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t3_refetch", bus.state, 1);
    chk("t3_clear", bus.trap_cause, 0);
    // plan 4: illegal ld+st, then data segv
    r0 = int'(bus.retired);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 1, 1, 2'b11, 1);
    chk("t4_no_commit", {bus.pc_inc, bus.reg_write}, 0);
    drive(1, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t4_cause", bus.trap_cause, 2);
    chk("t4_ret", bus.retired, r0);
    drive(0, 0, 32'h4444_0004, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0);
    drive(0, 1, '0, 0, 0, 1, 1, 0, 1, 0, 2'b01, 0);
    drive(0, 1, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t4_dsegv", bus.trap_cause, 3);
    // plan 5: deferred halt in store, immediate halt in fetch
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t5_halt_kept", bus.trap_cause, 3);
    to_exec(32'h5555_0005);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 0);
    drive(0, 1, '0, 0, 0, 0, 1, 0, 0, 1, 2'b10, 0);
    drive(0, 1, '0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 1);
    chk("t5_st_pc", bus.pc_inc, 1);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t5_halted", bus.state, 0);
    r0 = int'(bus.retired);
    drive(1, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    drive(0, 1, 32'h6666_0006, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t5_fetch_halt", bus.state, 0);
    chk("t5_fetch_ret", bus.retired, r0);
    // plan 6: counter wrap, then reset inside WAIT_LOAD
    r0 = int'(bus.retired);
    for (int i = 0; i < 17; i++) begin
      to_exec(32'(i));
      drive(0, 1, '0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1);
    end
    drive(0, 0, '0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    chk("t6_wrap", bus.retired, (r0 + 1) % 16);
    to_exec(32'h7777_0007);
    drive(0, 0, '0, 0, 0, 0, 0, 0, 1, 0, 2'b01, 0);
    drive(0, 0, '0, 0, 0, 0, 1, 0, 1, 0, 2'b01, 0);
    chk("t6_in_load", bus.state, 3);
    mid_reset("t6_rst");
    // random phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) mid_reset("rnd_rst");
      else
        drive(1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0, $urandom,
              $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 5,
              $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 6,
              $urandom_range(0, 15) == 0, $urandom_range(0, 9) < 3,
              $urandom_range(0, 9) < 3, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
